// File: rtl/bridge_cmd_mbox.sv
// bridge_cmd_mbox: bridge-mapped host and target command mailboxes.
// Host commands run through a small FSM; target commands drain from a queue.
module bridge_cmd_mbox #(
    parameter int          NPARAM   = 4,
    parameter int          TQ_DEPTH = 4,
    parameter logic [23:0] TIMEOUT  = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bridge_endian_little,
    input  logic [31:0]          bridge_addr,
    input  logic                 bridge_rd,
    output logic [31:0]          bridge_rd_data,
    input  logic                 bridge_wr,
    input  logic [31:0]          bridge_wr_data,
    input  logic                 status_boot_done,
    input  logic                 status_setup_done,
    input  logic                 status_running,
    output logic                 reset_n,
    output logic                 hc_valid,
    output logic [15:0]          hc_cmd,
    output logic [32*NPARAM-1:0] hc_param,
    input  logic                 hc_done,
    input  logic [15:0]          hc_code,
    input  logic [32*NPARAM-1:0] hc_resp,
    input  logic                 tq_push,
    input  logic [15:0]          tq_cmd,
    input  logic [32*NPARAM-1:0] tq_param,
    output logic                 tq_full,
    output logic                 tr_valid,
    output logic [15:0]          tr_code
);
    localparam int PW = 32 * NPARAM;
    localparam int AW = (TQ_DEPTH > 1) ? $clog2(TQ_DEPTH) : 1;
    localparam int CW = $clog2(TQ_DEPTH + 1);

    typedef enum logic [1:0] {H_IDLE, H_PARSE, H_WAIT_CORE, H_DONE} host_state_t;
    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_WAIT} tgt_state_t;

    // Little-endian bridges swap the two bytes inside each 16-bit half.
    function automatic logic [31:0] f_swap(input logic [31:0] d);
        return {d[23:16], d[31:24], d[7:0], d[15:8]};
    endfunction

    logic [2:0]  r_endian;
    logic [31:0] r_rd_data;
    logic        w_little;
    logic [31:0] w_wdata;
    logic        w_host_sel;
    logic        w_tgt_sel;
    logic [7:0]  w_off;
    logic        w_hwr;
    logic        w_twr;
    logic        w_cmd_wr;
    logic [31:0] w_rd_word;
    logic        w_unused_addr;

    host_state_t r_hstate;
    logic [15:0] r_hcmd;
    logic [15:0] r_hcode;
    logic [31:0] r_h0;
    logic [31:0] r_hpar [NPARAM];
    logic [31:0] r_hrsp [NPARAM];
    logic        r_core_rst_n;
    logic        r_hc_valid;
    logic [PW-1:0] r_hc_param;
    logic [PW-1:0] w_hpar_flat;
    logic [15:0] w_status_code;

    tgt_state_t  r_tstate;
    logic [31:0] r_t0;
    logic [31:0] r_tpar [NPARAM];
    logic [31:0] r_trsp [NPARAM];
    logic [15:0] r_thold_cmd;
    logic [PW-1:0] r_thold_par;
    logic [23:0] r_timer;
    logic        r_tr_valid;
    logic [15:0] r_tr_code;

    logic [15:0]   r_qcmd [TQ_DEPTH];
    logic [PW-1:0] r_qpar [TQ_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_setup_d;
    logic          r_edge_pend;
    logic          w_full;
    logic          w_setup_edge;
    logic          w_enq;
    logic          w_deq;
    logic [15:0]   w_enq_cmd;
    logic [PW-1:0] w_enq_par;

    assign w_little      = r_endian[2];
    assign w_wdata       = w_little ? f_swap(bridge_wr_data) : bridge_wr_data;
    assign w_host_sel    = (bridge_addr[31:24] == 8'hF8) && (bridge_addr[15:8] == 8'h00);
    assign w_tgt_sel     = (bridge_addr[31:24] == 8'hF8) && (bridge_addr[15:8] == 8'h10);
    assign w_off         = bridge_addr[7:0];
    assign w_hwr         = bridge_wr && w_host_sel;
    assign w_twr         = bridge_wr && w_tgt_sel;
    assign w_cmd_wr      = w_hwr && (w_off == 8'h00) && (w_wdata[31:16] == 16'h434D);
    assign w_unused_addr = ^bridge_addr[23:16];

    assign w_full       = (r_cnt == CW'(TQ_DEPTH));
    assign w_setup_edge = status_setup_done && !r_setup_d;
    assign w_enq        = (tq_push || w_setup_edge || r_edge_pend) && !w_full;
    assign w_deq        = (r_tstate == T_IDLE) && (r_cnt != '0);
    assign w_enq_cmd    = tq_push ? tq_cmd : 16'h0140;
    assign w_enq_par    = tq_push ? tq_param : '0;

    assign bridge_rd_data = r_rd_data;
    assign reset_n        = r_core_rst_n;
    assign hc_valid       = r_hc_valid;
    assign hc_cmd         = r_hcmd;
    assign hc_param       = r_hc_param;
    assign tq_full        = w_full;
    assign tr_valid       = r_tr_valid;
    assign tr_code        = r_tr_code;

    always_comb begin
        w_status_code = 16'd3;
        if (!status_boot_done) begin
            w_status_code = 16'd1;
        end else if (status_setup_done) begin
            w_status_code = 16'd2;
        end else if (status_running) begin
            w_status_code = 16'd4;
        end
    end

    always_comb begin
        w_hpar_flat = '0;
        for (int i = 0; i < NPARAM; i++) begin
            w_hpar_flat[32*i +: 32] = r_hpar[i];
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_host_sel || w_tgt_sel) begin
            if (w_off == 8'h00) w_rd_word = w_host_sel ? r_h0 : r_t0;
            if (w_off == 8'h04) w_rd_word = 32'h20;
            if (w_off == 8'h08) w_rd_word = 32'h40;
            for (int i = 0; i < NPARAM; i++) begin
                if (w_off == 8'(64 + 4*i))
                    w_rd_word = w_host_sel ? r_hrsp[i] : r_trsp[i];
                if (w_off == 8'(32 + 4*i))
                    w_rd_word = w_host_sel ? r_hpar[i] : r_tpar[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_endian  <= '0;
            r_rd_data <= '0;
        end else begin
            r_endian <= {r_endian[1:0], bridge_endian_little};
            if (bridge_rd) r_rd_data <= w_little ? f_swap(w_rd_word) : w_rd_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hstate     <= H_IDLE;
            r_hcmd       <= '0;
            r_hcode      <= '0;
            r_h0         <= '0;
            r_core_rst_n <= 1'b0;
            r_hc_valid   <= 1'b0;
            r_hc_param   <= '0;
            for (int i = 0; i < NPARAM; i++) begin
                r_hpar[i] <= '0;
                r_hrsp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NPARAM; i++) begin
                if (w_hwr && w_off == 8'(32 + 4*i)) r_hpar[i] <= w_wdata;
            end
            unique case (r_hstate)
                H_IDLE: begin
                    if (w_cmd_wr) begin
                        r_hcmd   <= w_wdata[15:0];
                        r_h0     <= w_wdata;
                        r_hstate <= H_PARSE;
                    end
                end
                H_PARSE: begin
                    r_h0     <= {16'h4255, r_hcmd};
                    r_hcode  <= 16'h0000;
                    r_hstate <= H_DONE;
                    case (r_hcmd)
                        16'h0000: r_hcode <= w_status_code;
                        16'h0010: r_core_rst_n <= 1'b0;
                        16'h0011: r_core_rst_n <= 1'b1;
                        default: begin
                            r_hc_valid <= 1'b1;
                            r_hc_param <= w_hpar_flat;
                            r_hstate   <= H_WAIT_CORE;
                        end
                    endcase
                end
                H_WAIT_CORE: begin
                    if (hc_done) begin
                        for (int i = 0; i < NPARAM; i++) begin
                            r_hrsp[i] <= hc_resp[32*i +: 32];
                        end
                        r_hcode    <= hc_code;
                        r_hc_valid <= 1'b0;
                        r_hstate   <= H_DONE;
                    end
                end
                H_DONE: begin
                    r_h0     <= {16'h4F4B, r_hcode};
                    r_hstate <= H_IDLE;
                end
            endcase
        end
    end

    // A setup edge that collides with tq_push waits one cycle for a slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_setup_d   <= 1'b0;
            r_edge_pend <= 1'b0;
            for (int i = 0; i < TQ_DEPTH; i++) begin
                r_qcmd[i] <= '0;
                r_qpar[i] <= '0;
            end
        end else begin
            r_setup_d   <= status_setup_done;
            r_edge_pend <= tq_push && (w_setup_edge || r_edge_pend);
            if (w_enq) begin
                r_qcmd[r_wp] <= w_enq_cmd;
                r_qpar[r_wp] <= w_enq_par;
                r_wp         <= r_wp + 1'b1;
            end
            if (w_deq) r_rp <= r_rp + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tstate    <= T_IDLE;
            r_t0        <= '0;
            r_thold_cmd <= '0;
            r_thold_par <= '0;
            r_timer     <= '0;
            r_tr_valid  <= 1'b0;
            r_tr_code   <= '0;
            for (int i = 0; i < NPARAM; i++) begin
                r_tpar[i] <= '0;
                r_trsp[i] <= '0;
            end
        end else begin
            r_tr_valid <= 1'b0;
            for (int i = 0; i < NPARAM; i++) begin
                if (w_twr && w_off == 8'(64 + 4*i)) r_trsp[i] <= w_wdata;
            end
            if (w_twr && w_off == 8'h00) r_t0 <= w_wdata;
            unique case (r_tstate)
                T_IDLE: begin
                    if (w_deq) begin
                        r_thold_cmd <= r_qcmd[r_rp];
                        r_thold_par <= r_qpar[r_rp];
                        r_tstate    <= T_ISSUE;
                    end
                end
                T_ISSUE: begin
                    for (int i = 0; i < NPARAM; i++) begin
                        r_tpar[i] <= r_thold_par[32*i +: 32];
                    end
                    r_t0     <= {16'h636D, r_thold_cmd};
                    r_timer  <= '0;
                    r_tstate <= T_WAIT;
                end
                T_WAIT: begin
                    if (r_t0[31:16] == 16'h6F6B) begin
                        r_tr_valid <= 1'b1;
                        r_tr_code  <= r_t0[15:0];
                        r_tstate   <= T_IDLE;
                    end else if (r_timer == TIMEOUT) begin
                        r_tr_valid <= 1'b1;
                        r_tr_code  <= 16'hFFFE;
                        r_t0       <= '0;
                        r_tstate   <= T_IDLE;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                default: r_tstate <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bridge_cmd_mbox.sv
// tb_bridge_cmd_mbox: directed and randomized checks of bridge_cmd_mbox
// against a mailbox/queue reference model.
module tb_bridge_cmd_mbox;
    localparam int          NP  = 4;
    localparam int          TQD = 4;
    localparam logic [23:0] TO  = 24'd50;
    localparam logic [31:0] HB  = 32'hF8A50000;
    localparam logic [31:0] TB  = 32'hF83C1000;
    localparam logic [2:0]  ST [6] = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b101, 3'b111};

    typedef struct packed {
        logic [15:0]     c;
        logic [32*NP-1:0] p;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bridge_endian_little = 1'b0;
    logic [31:0] bridge_addr = '0;
    logic bridge_rd = 1'b0;
    logic [31:0] bridge_rd_data;
    logic bridge_wr = 1'b0;
    logic [31:0] bridge_wr_data = '0;
    logic status_boot_done = 1'b0;
    logic status_setup_done = 1'b0;
    logic status_running = 1'b0;
    logic reset_n;
    logic hc_valid;
    logic [15:0] hc_cmd;
    logic [32*NP-1:0] hc_param;
    logic hc_done = 1'b0;
    logic [15:0] hc_code = '0;
    logic [32*NP-1:0] hc_resp = '0;
    logic tq_push = 1'b0;
    logic [15:0] tq_cmd = '0;
    logic [32*NP-1:0] tq_param = '0;
    logic tq_full;
    logic tr_valid;
    logic [15:0] tr_code;

    int vec = 0;
    int miss = 0;
    logic [15:0] got_code [$];
    logic [15:0] exp_code [$];
    logic [31:0] m_hpar [NP];

    always #5 clk = ~clk;

    bridge_cmd_mbox #(.NPARAM(NP), .TQ_DEPTH(TQD), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .bridge_endian_little(bridge_endian_little),
        .bridge_addr(bridge_addr), .bridge_rd(bridge_rd),
        .bridge_rd_data(bridge_rd_data), .bridge_wr(bridge_wr),
        .bridge_wr_data(bridge_wr_data),
        .status_boot_done(status_boot_done),
        .status_setup_done(status_setup_done),
        .status_running(status_running), .reset_n(reset_n),
        .hc_valid(hc_valid), .hc_cmd(hc_cmd), .hc_param(hc_param),
        .hc_done(hc_done), .hc_code(hc_code), .hc_resp(hc_resp),
        .tq_push(tq_push), .tq_cmd(tq_cmd), .tq_param(tq_param),
        .tq_full(tq_full), .tr_valid(tr_valid), .tr_code(tr_code)
    );

    always @(negedge clk) begin
        if (tr_valid) got_code.push_back(tr_code);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] sw16(input logic [31:0] d);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        return {b[2], b[3], b[0], b[1]};
    endfunction

    // Status code: booting, else setup, else running, else idle.
    function automatic logic [15:0] exp_status(input logic boot, input logic setup,
                                               input logic run);
        if (!boot) return 16'd1;
        if (setup) return 16'd2;
        if (run) return 16'd4;
        return 16'd3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bridge_addr = a;
        bridge_wr_data = d;
        bridge_wr = 1'b1;
        tick();
        bridge_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bridge_addr = a;
        bridge_rd = 1'b1;
        tick();
        bridge_rd = 1'b0;
        d = bridge_rd_data;
    endtask

    task automatic poll(input logic [31:0] a, input logic [31:0] want,
                        output logic [31:0] d);
        int k = 0;
        rd(a, d);
        while (d !== want && k < 20) begin
            rd(a, d);
            k++;
        end
    endtask

    task automatic push(input ent_t e);
        tq_cmd = e.c;
        tq_param = e.p;
        tq_push = 1'b1;
        tick();
        tq_push = 1'b0;
    endtask

    task automatic cmp_codes(input string tag);
        chk({tag, "_cnt"}, 32'(got_code.size()), 32'(exp_code.size()));
        for (int i = 0; i < exp_code.size() && i < got_code.size(); i++) begin
            chk({tag, "_code"}, 32'(got_code[i]), 32'(exp_code[i]));
        end
        got_code.delete();
        exp_code.delete();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] old0;
        logic [15:0] cmd;
        logic [15:0] code;
        logic [31:0] r [NP];
        ent_t e;
        ent_t order [$];
        int pending;
        int k;

        for (int i = 0; i < NP; i++) m_hpar[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reset_n", 32'(reset_n), 32'd0);
        chk("rst_hc_valid", 32'(hc_valid), 32'd0);
        chk("rst_tr_valid", 32'(tr_valid), 32'd0);
        chk("rst_tq_full", 32'(tq_full), 32'd0);
        chk("rst_rd_data", bridge_rd_data, 32'd0);
        reset = 1'b0;
        tick();
        rd(HB, d);                 chk("rst_h0", d, 32'd0);
        rd(HB + 32'h4, d);         chk("h_pptr", d, 32'h20);
        rd(TB + 32'h8, d);         chk("t_rptr", d, 32'h40);
        rd(HB + 32'h20, d);        chk("rst_hpar", d, 32'd0);
        wr(32'hF8002020, 32'hDEADBEEF);
        rd(32'hF8002020, d);       chk("unmapped_rd", d, 32'd0);
        rd(HB + 32'h20, d);        chk("unmapped_wr", d, 32'd0);

        wr(HB, 32'h434D0011);
        tick(); tick();
        chk("rst_n_on", 32'(reset_n), 32'd1);
        rd(HB, d);                 chk("h0_0011", d, 32'h4F4B0000);
        wr(HB, 32'h434D0010);
        tick(); tick();
        chk("rst_n_off", 32'(reset_n), 32'd0);
        rd(HB, d);                 chk("h0_0010", d, 32'h4F4B0000);
        wr(HB, 32'h434D0011);
        tick(); tick();

        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                cmd = 16'h0080;
                m_hpar[0] = 32'd5;
                wr(HB + 32'h20, 32'd5);
                code = 16'd2;
                r[0] = 32'd7;
                for (int i = 1; i < NP; i++) r[i] = $urandom;
            end else begin
                cmd = 16'($urandom_range(32'h0012, 32'hFFFF));
                for (int i = 0; i < NP; i++) begin
                    m_hpar[i] = $urandom;
                    wr(HB + 32'h20 + 32'(4*i), m_hpar[i]);
                end
                code = 16'($urandom);
                for (int i = 0; i < NP; i++) r[i] = $urandom;
            end
            wr(HB, {16'h434D, cmd});
            k = 0;
            while (!hc_valid && k < 10) begin
                tick();
                k++;
            end
            chk("hc_valid_up", 32'(hc_valid), 32'd1);
            chk("hc_cmd", 32'(hc_cmd), 32'(cmd));
            for (int i = 0; i < NP; i++) chk("hc_param", hc_param[32*i +: 32], m_hpar[i]);
            rd(HB, d);             chk("h0_busy", d, {16'h4255, cmd});
            old0 = m_hpar[0];
            m_hpar[0] = ~m_hpar[0];
            wr(HB + 32'h20, m_hpar[0]);
            wr(HB, 32'h434D0010);
            tick();
            chk("hc_frozen", hc_param[31:0], old0);
            chk("hc_cmd_hold", 32'(hc_cmd), 32'(cmd));
            chk("hc_still_valid", 32'(hc_valid), 32'd1);
            hc_code = code;
            for (int i = 0; i < NP; i++) hc_resp[32*i +: 32] = r[i];
            hc_done = 1'b1;
            tick();
            hc_done = 1'b0;
            chk("hc_valid_dn", 32'(hc_valid), 32'd0);
            tick();
            rd(HB, d);             chk("h0_core_done", d, {16'h4F4B, code});
            for (int i = 0; i < NP; i++) begin
                rd(HB + 32'h40 + 32'(4*i), d);
                chk("h_resp", d, r[i]);
            end
            chk("busy_cmd_ignored", 32'(reset_n), 32'd1);
        end

        for (int s = 0; s < 6; s++) begin
            status_boot_done = ST[s][2];
            status_running = ST[s][1];
            status_setup_done = ST[s][0];
            wr(HB, 32'h434D0000);
            tick(); tick();
            rd(HB, d);
            chk("h_status", d, {16'h4F4B, exp_status(ST[s][2], ST[s][0], ST[s][1])});
        end

        poll(TB, 32'h636D0140, d);
        chk("setup_edge_cmd", d, 32'h636D0140);
        for (int i = 0; i < NP; i++) begin
            rd(TB + 32'h20 + 32'(4*i), d);
            chk("setup_edge_par", d, 32'd0);
        end
        code = 16'($urandom);
        wr(TB, {16'h6F6B, code});
        exp_code.push_back(code);
        repeat (3) tick();
        cmp_codes("setup_tr");

        bridge_endian_little = 1'b1;
        repeat (4) tick();
        wr(HB, 32'h4D430000);
        tick(); tick();
        rd(HB, d);                 chk("le_status", d, sw16({16'h4F4B, 16'd2}));
        rd(HB + 32'h4, d);         chk("le_pptr", d, sw16(32'h20));
        old0 = $urandom;
        wr(HB + 32'h20, old0);
        rd(HB + 32'h20, d);        chk("le_par_rt", d, old0);
        bridge_endian_little = 1'b0;
        repeat (4) tick();
        rd(HB + 32'h20, d);        chk("le_par_be", d, sw16(old0));

        e.c = 16'($urandom);
        for (int i = 0; i < NP; i++) e.p[32*i +: 32] = $urandom;
        push(e);
        order.push_back(e);
        poll(TB, {16'h636D, e.c}, d);
        chk("tq_first_issue", d, {16'h636D, e.c});
        pending = 0;
        for (int j = 0; j <= TQD; j++) begin
            e.c = 16'($urandom);
            for (int i = 0; i < NP; i++) e.p[32*i +: 32] = $urandom;
            push(e);
            if (pending < TQD) begin
                pending++;
                order.push_back(e);
            end
            chk("tq_full", 32'(tq_full), 32'(pending == TQD));
        end
        foreach (order[n]) begin
            poll(TB, {16'h636D, order[n].c}, d);
            chk("tq_issue", d, {16'h636D, order[n].c});
            for (int i = 0; i < NP; i++) begin
                rd(TB + 32'h20 + 32'(4*i), d);
                chk("tq_par", d, order[n].p[32*i +: 32]);
            end
            code = 16'($urandom);
            wr(TB, {16'h6F6B, code});
            exp_code.push_back(code);
        end
        repeat (4) tick();
        cmp_codes("tq_tr");
        chk("tq_drained", 32'(tq_full), 32'd0);
        rd(TB, d);                 chk("tq_dropped", d, {16'h6F6B, code});

        e.c = 16'($urandom);
        e.p = '0;
        push(e);
        k = 0;
        while (!tr_valid && k < int'(TO) + 20) begin
            tick();
            k++;
        end
        chk("to_valid", 32'(tr_valid), 32'd1);
        chk("to_code", 32'(tr_code), 32'hFFFE);
        chk("to_latency_ok", 32'(k >= int'(TO) && k <= int'(TO) + 4), 32'd1);
        tick();
        chk("to_pulse", 32'(tr_valid), 32'd0);
        rd(TB, d);                 chk("to_t0", d, 32'd0);
        got_code.delete();

        wr(HB, 32'h434D0123);
        k = 0;
        while (!hc_valid && k < 10) begin
            tick();
            k++;
        end
        chk("mid_valid", 32'(hc_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_hc_valid", 32'(hc_valid), 32'd0);
        chk("mid_reset_n", 32'(reset_n), 32'd0);
        chk("mid_tr_valid", 32'(tr_valid), 32'd0);
        tick();
        reset = 1'b0;
        rd(HB, d);                 chk("mid_h0", d, 32'd0);
        rd(HB + 32'h40, d);        chk("mid_hresp", d, 32'd0);
        rd(HB + 32'h20, d);        chk("mid_hpar", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
